// File: rtl/uart_rx_deframe.sv
// ---------------------------------------------------------------------------
// uart_rx_deframe
//
// Purpose:
//   Takes a complete 11-bit UART frame from the serial-to-parallel stage,
//   checks its parity and framing, and queues the data byte with its error
//   flags in a small FIFO for the consumer.
//
// Parameters:
//   PARITY_EN  - 1: check the parity bit, 0: ignore bit 9
//   PARITY_ODD - 1: odd parity, 0: even parity
//   DEPTH      - FIFO entries (power of two, at least 2)
//
// Ports:
//   baud_clk      in   16x oversample tick clock
//   reset_n       in   asynchronous active-low reset
//   recieved_flag in   frame-complete indication (rising edge is used)
//   data_parll    in   frame: [0] start, [8:1] data LSB-first, [9] parity,
//                      [10] stop
//   rd_en         in   pop the FIFO head
//   clr_ovr       in   clear the sticky overrun flag
//   rx_valid      out  FIFO non-empty
//   rx_data       out  head data byte (0 when empty)
//   rx_perr       out  head entry parity error (0 when empty)
//   rx_ferr       out  head entry framing error (0 when empty)
//   overrun       out  sticky: a frame was dropped
//   fifo_count    out  occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_rx_deframe #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter int DEPTH      = 4
) (
    input  logic                     baud_clk,
    input  logic                     reset_n,
    input  logic                     recieved_flag,
    input  logic [10:0]              data_parll,
    input  logic                     rd_en,
    input  logic                     clr_ovr,
    output logic                     rx_valid,
    output logic [7:0]               rx_data,
    output logic                     rx_perr,
    output logic                     rx_ferr,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;

    logic            r_flagSample;
    logic            r_flagPrev;
    logic            w_flagRise;

    logic [10:0]     r_frame;
    logic            r_perr;
    logic            r_ferr;

    logic            w_capture;
    logic            w_doCheck;
    logic            w_storeReq;

    logic [9:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [AW:0]     r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_ovrSet;
    logic [9:0]      w_head;

    logic            r_overrun;

    // The flag is sampled once and compared with the previous sample, so
    // a flag held high for many cycles still yields a single event.  The
    // history resets low, so a flag already high after reset counts as a
    // fresh rising edge.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flagSample <= 1'b0;
            r_flagPrev   <= 1'b0;
        end else begin
            r_flagSample <= recieved_flag;
            r_flagPrev   <= r_flagSample;
        end
    end

    assign w_flagRise = r_flagSample & ~r_flagPrev;

    // FSM state register.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next-state logic: only IDLE waits; CHECK and STORE each last one
    // cycle.
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (w_flagRise) w_stateNext = CHECK;
            CHECK:   w_stateNext = STORE;
            STORE:   w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // FSM outputs: strobes for the datapath.
    always_comb begin
        w_capture  = 1'b0;
        w_doCheck  = 1'b0;
        w_storeReq = 1'b0;
        unique case (r_state)
            IDLE:    w_capture  = w_flagRise;
            CHECK:   w_doCheck  = 1'b1;
            STORE:   w_storeReq = 1'b1;
            default: ;
        endcase
    end

    // Frame capture and error evaluation.  The idle frame value is all
    // ones, i.e. the line-idle pattern.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame <= 11'h7FF;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_frame <= data_parll;
            end
            if (w_doCheck) begin
                r_perr <= PARITY_EN & ((^r_frame[9:1]) != PARITY_ODD);
                r_ferr <= r_frame[0] | ~r_frame[10];
            end
        end
    end

    // A full FIFO still accepts the push when the head is popped in the
    // same cycle.  A rising edge while the FSM is busy is lost and flagged.
    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = rd_en & (r_count != '0);
    assign w_push   = w_storeReq & (~w_full | w_pop);
    assign w_ovrSet = (w_storeReq & ~w_push) | (w_flagRise & (r_state != IDLE));

    // Storage array; contents need no reset since the pointers define
    // what is valid.
    always_ff @(posedge baud_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {r_ferr, r_perr, r_frame[8:1]};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun; a new drop wins over a clear in the same cycle.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovrSet) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_head     = r_mem[r_rdPtr];
    assign rx_valid   = (r_count != '0);
    assign rx_data    = rx_valid ? w_head[7:0] : 8'h00;
    assign rx_perr    = rx_valid ? w_head[8]   : 1'b0;
    assign rx_ferr    = rx_valid ? w_head[9]   : 1'b0;
    assign overrun    = r_overrun;
    assign fifo_count = r_count;

endmodule

// File: doc/uart_rx_deframe.md
UART_RX_DEFRAME -- requirements
Module: uart_rx_deframe

Interface
REQ-001 SHALL have parameter PARITY_EN, default 1, meaning parity bit checked (0 = bit 9 ignored).
REQ-002 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even parity.
REQ-003 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, >=2).
REQ-004 SHALL have port baud_clk  input  1  clock (16x oversample tick clock).
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port recieved_flag  input  1  frame-complete indication from serial-to-parallel stage.
REQ-007 SHALL have port data_parll  input  11  frame: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-008 SHALL have port rd_en  input  1  pop FIFO head.
REQ-009 SHALL have port clr_ovr  input  1  clear sticky overrun.
REQ-010 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port rx_data  output  8  head data byte.
REQ-012 SHALL have port rx_perr  output  1  head entry parity error.
REQ-013 SHALL have port rx_ferr  output  1  head entry framing error.
REQ-014 SHALL have port overrun  output  1  sticky: frame dropped.
REQ-015 SHALL have port fifo_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL register recieved_flag and detect its rising edge (flag high, previous sample low); level duration SHALL not matter.
REQ-017 SHALL implement FSM IDLE, CHECK, STORE; IDLE->CHECK on rising edge, capturing data_parll into frame_q that cycle.
REQ-018 CHECK SHALL register perr = PARITY_EN & (^frame_q[9:1] != PARITY_ODD) and ferr = frame_q[0] | ~frame_q[10]; unconditional transition to STORE.
REQ-019 STORE SHALL push {ferr, perr, frame_q[8:1]} if FIFO not full, else set overrun and discard; unconditional transition to IDLE.
REQ-020 Latency: rx_valid SHALL rise on the 3rd baud_clk edge after the edge sampling the flag rise, when FIFO was empty.
REQ-021 Flag rising edge detected in CHECK or STORE SHALL set overrun and be discarded; in-flight frame unaffected.
REQ-022 rd_en with rx_valid SHALL remove head next edge; rd_en with empty FIFO SHALL be ignored (no pointer/count change).
REQ-023 Push and pop same cycle SHALL leave fifo_count unchanged; on full FIFO, pop-same-cycle SHALL permit the push (no overrun).
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-025 rx_data/rx_perr/rx_ferr SHALL show head entry combinationally from storage; value undefined-but-stable when empty (drive 0).
REQ-026 overrun SHALL stay set until clr_ovr; set and clear same cycle SHALL leave overrun set.
REQ-027 Errored frames SHALL still be stored with flags; only FIFO-full or busy-FSM drops frames.

Reset
REQ-028 reset_n low SHALL asynchronously force FSM IDLE, pointers 0, fifo_count 0, rx_valid 0, overrun 0, frame_q 11'h7FF, flag history 0, head outputs 0.
REQ-029 Reset mid-CHECK/STORE SHALL abort frame with no push; FIFO contents discarded.
REQ-030 After release, flag already high SHALL count as a rising edge on first sampled cycle.

Verification
REQ-031 Frame 11'b1_0_10100101_0 (data 0xA5, even parity 0, stop 1), PARITY_ODD=0 -> rx_data 0xA5, perr 0, ferr 0, rx_valid 3 edges after flag edge.
REQ-032 Same frame with bit 9 = 1 -> entry stored, rx_perr 1; PARITY_EN=0 -> rx_perr 0.
REQ-033 Stop bit 0 (data_parll[10]=0) or start bit 1 -> rx_ferr 1, data still delivered.
REQ-034 Push 5 frames (0x01..0x05), DEPTH=4, no reads -> fifo_count 4, overrun 1, reads return 0x01..0x04 in order; clr_ovr -> overrun 0.
REQ-035 FIFO full, rd_en in STORE cycle of 5th frame -> no overrun, fifo_count stays 4, final read 0x05.
REQ-036 reset_n pulsed during CHECK -> rx_valid 0, fifo_count 0, next clean frame delivered normally.
